// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver with per-channel off/on/pwm/breathe modes.
// Config writes are staged and take effect only at PWM period boundaries.
module led_pwm_bank #(
    parameter int CHANNELS     = 8,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 94,
    parameter int BREATHE_STEP = 4,
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] leds,
    output logic                period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
    localparam logic [PW-1:0]       PS_LAST   = PW'(PRESCALE - 1);
    localparam logic [BW-1:0]       STEP_LAST = BW'(BREATHE_STEP - 1);
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [AW:0]         CH_LIM    = (AW + 1)'(CHANNELS);

    localparam logic [1:0] M_OFF = 2'd0;
    localparam logic [1:0] M_ON  = 2'd1;
    localparam logic [1:0] M_PWM = 2'd2;
    localparam logic [1:0] M_BRE = 2'd3;

    logic [PW-1:0]       prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bri;
    logic                up;
    logic [BW-1:0]       step_cnt;
    logic                tick;
    logic                wrap;
    logic                addr_ok;

    logic [CHANNELS-1:0][1:0]          pend_mode, pend_mode_n;
    logic [CHANNELS-1:0][1:0]          act_mode, act_mode_n;
    logic [CHANNELS-1:0][PWM_BITS-1:0] pend_duty, pend_duty_n;
    logic [CHANNELS-1:0][PWM_BITS-1:0] act_duty, act_duty_n;
    logic [CHANNELS-1:0]               led_n;

    assign tick    = (prescaler == PS_LAST);
    assign wrap    = tick && (pwm_cnt == MAX);
    assign addr_ok = ({1'b0, cfg_addr} < CH_LIM);

    function automatic logic lit(
        input logic [1:0]          mode,
        input logic [PWM_BITS-1:0] duty,
        input logic [PWM_BITS-1:0] cnt,
        input logic [PWM_BITS-1:0] level
    );
        logic [PWM_BITS-1:0] lim;
        lim = (level < duty) ? level : duty;
        unique case (mode)
            M_OFF:   lit = 1'b0;
            M_ON:    lit = 1'b1;
            M_PWM:   lit = (cnt < duty);
            M_BRE:   lit = (cnt < lim);
            default: lit = 1'b0;
        endcase
    endfunction

    // Pending update feeds straight into active so a write on the wrap edge lands now.
    always_comb begin
        pend_mode_n = pend_mode;
        pend_duty_n = pend_duty;
        act_mode_n  = act_mode;
        act_duty_n  = act_duty;
        led_n       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && addr_ok && (cfg_addr == AW'(i))) begin
                pend_mode_n[i] = cfg_mode;
                pend_duty_n[i] = cfg_duty;
            end
            if (wrap) begin
                act_mode_n[i] = pend_mode_n[i];
                act_duty_n[i] = pend_duty_n[i];
            end
            led_n[i] = lit(act_mode[i], act_duty[i], pwm_cnt, bri);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            bri          <= '0;
            up           <= 1'b1;
            step_cnt     <= '0;
            pend_mode    <= '0;
            pend_duty    <= '0;
            act_mode     <= '0;
            act_duty     <= '0;
            leds         <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            pend_mode    <= pend_mode_n;
            pend_duty    <= pend_duty_n;
            act_mode     <= act_mode_n;
            act_duty     <= act_duty_n;
            leds         <= led_n;
            period_start <= wrap;
            if (wrap) begin
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (up) begin
                        bri <= bri + 1'b1;
                        if (bri == (MAX - 1'b1)) up <= 1'b0;
                    end else begin
                        bri <= bri - 1'b1;
                        if (bri == PWM_BITS'(1)) up <= 1'b1;
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: 6 channels, 4-bit PWM, 32-cycle period.
module tb_led_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_duty = '0;
    logic [5:0] leds;
    logic       period_start;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt[6];
    int first0;
    int last0;

    led_pwm_bank #(
        .CHANNELS(6), .PWM_BITS(4), .PRESCALE(2), .BREATHE_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .leds(leds),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1);
    end

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_mode = m; cfg_duty = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = period_start;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: period_start seen=0 required=1", tag);
        end
    endtask

    // Called at the negedge of a period_start cycle; ends on the next one.
    task automatic measure();
        for (int c = 0; c < 6; c++) cnt[c] = 0;
        first0 = -1;
        last0  = -1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            for (int c = 0; c < 6; c++) if (leds[c]) cnt[c]++;
            if (leds[0]) begin
                if (first0 < 0) first0 = k;
                last0 = k;
            end
        end
    endtask

    task automatic test_reset();
        int first;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wr(3'd0, 2'd1, 4'd0);
        wait_ps("rst_ps0");
        @(negedge clk);
        n_cmp++;
        if (leds[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL ch0_on: leds[0]=%b required=1", leds[0]);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (leds !== 6'b0 || period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_clear: leds=%b ps=%b required 000000/0", leds, period_start);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (period_start && first < 0) first = n;
        end
        n_cmp++;
        if (first != 32) begin
            n_bad++;
            $display("FAIL first_ps: cycle=%0d required=32", first);
        end
        n_cmp++;
        if (leds !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_mode_off: leds=%b required=000000", leds);
        end
    endtask

    task automatic test_pwm();
        wr(3'd0, 2'd2, 4'd4);
        wait_ps("pwm_ps");
        measure();
        n_cmp++;
        if (cnt[0] != 8) begin
            n_bad++;
            $display("FAIL pwm_cnt: high=%0d required=8", cnt[0]);
        end
        n_cmp++;
        if (first0 != 1 || last0 != 8) begin
            n_bad++;
            $display("FAIL pwm_pos: first=%0d last=%0d required 1/8", first0, last0);
        end
        n_cmp++;
        if (cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5] != 0) begin
            n_bad++;
            $display("FAIL pwm_others: high=%0d required=0",
                     cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5]);
        end
    endtask

    task automatic test_boundary();
        bit early = 1'b0;
        bit seen  = 1'b0;
        repeat (5) @(negedge clk);
        wr(3'd1, 2'd1, 4'd0);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (leds[1]) early = 1'b1;
            seen = period_start;
        end
        n_cmp++;
        if (early || !seen) begin
            n_bad++;
            $display("FAIL ch1_hold: early=%b seen=%b required 0/1", early, seen);
        end
        @(negedge clk);
        n_cmp++;
        if (leds[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL ch1_on: leds[1]=%b required=1", leds[1]);
        end
        repeat (30) @(negedge clk);
        wr(3'd1, 2'd0, 4'd0);
        n_cmp++;
        if (period_start !== 1'b1 || leds[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_edge: ps=%b leds[1]=%b required 1/1", period_start, leds[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (leds[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL ch1_fwd_off: leds[1]=%b required=0", leds[1]);
        end
        wr(3'd2, 2'd2, 4'd3);
        wr(3'd2, 2'd2, 4'd9);
        wait_ps("last_wins_ps");
        measure();
        n_cmp++;
        if (cnt[2] != 18) begin
            n_bad++;
            $display("FAIL last_wins: high=%0d required=18", cnt[2]);
        end
        n_cmp++;
        if (cnt[1] != 0 || cnt[0] != 8) begin
            n_bad++;
            $display("FAIL bnd_others: ch1=%0d ch0=%0d required 0/8", cnt[1], cnt[0]);
        end
    endtask

    task automatic test_breathe();
        int t;
        int tri_v;
        int cap;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr(3'd3, 2'd3, 4'd15);
        wr(3'd4, 2'd3, 4'd5);
        wait_ps("bre_ps");
        for (int p = 0; p < 35; p++) begin
            measure();
            t     = (p + 1) % 30;
            tri_v = (t <= 15) ? t : 30 - t;
            cap   = (tri_v < 5) ? tri_v : 5;
            n_cmp++;
            if (cnt[3] != 2 * tri_v) begin
                n_bad++;
                $display("FAIL bre_full p%0d: high=%0d required=%0d", p, cnt[3], 2 * tri_v);
            end
            n_cmp++;
            if (cnt[4] != 2 * cap) begin
                n_bad++;
                $display("FAIL bre_cap p%0d: high=%0d required=%0d", p, cnt[4], 2 * cap);
            end
        end
    endtask

    task automatic test_extremes();
        wr(3'd0, 2'd2, 4'd0);
        wr(3'd5, 2'd2, 4'd15);
        wait_ps("ext_ps");
        measure();
        n_cmp++;
        if (cnt[0] != 0) begin
            n_bad++;
            $display("FAIL duty0: high=%0d required=0", cnt[0]);
        end
        n_cmp++;
        if (cnt[5] != 30) begin
            n_bad++;
            $display("FAIL duty15: high=%0d required=30", cnt[5]);
        end
        wr(3'd7, 2'd1, 4'd15);
        wait_ps("addr_ps");
        measure();
        n_cmp++;
        if (cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 0 || cnt[5] != 30) begin
            n_bad++;
            $display("FAIL addr7: ch0=%0d ch1=%0d ch2=%0d ch5=%0d required 0/0/0/30",
                     cnt[0], cnt[1], cnt[2], cnt[5]);
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_boundary();
        test_breathe();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Parametrised multi-channel LED driver for the board top level. It replaces the "LEDs = slow free-running counter bits" scheme with per-channel, glitch-free PWM brightness. Each channel independently selects off, on, fixed-duty PWM, or a shared triangle "breathe" ramp. It runs in the PLL-derived core clock domain, is held in reset while the PLL is unlocked, and is configured by a simple single-cycle write port.

## Interface

Parameters:
- CHANNELS, 8: number of LED outputs, 1..16.
- PWM_BITS, 8: PWM counter and duty width, 2..12.
- PRESCALE, 94: core clocks per PWM counter step, ≥1 (24 MHz/94/256 ≈ 1 kHz period).
- BREATHE_STEP, 4: PWM periods per breathe level step, ≥1.

Ports:
- clk, in, 1: core clock. One clock only.
- rst, in, 1: reset, synchronous, active-high. Driven from !pll_lock at the top level.
- cfg_we, in, 1: write strobe, one cycle per write.
- cfg_addr, in, $clog2(CHANNELS) (min 1): target channel.
- cfg_mode, in, 2: 0 = off, 1 = on, 2 = pwm, 3 = breathe.
- cfg_duty, in, PWM_BITS: duty, or breathe ceiling.
- leds, out, CHANNELS: registered LED drives, 1 = lit.
- period_start, out, 1: one-cycle pulse marking the first cycle of each PWM period.

## Operation

- Prescaler: counts 0..PRESCALE-1 and wraps. `tick` = (prescaler == PRESCALE-1).
- PWM counter `pwm_cnt`, PWM_BITS wide: increments on tick, wraps MAX = 2^PWM_BITS-1 → 0.
- Boundary event `wrap` = tick && pwm_cnt == MAX.
- Per channel, two register sets:
  - Pending (mode, duty): written by cfg_we.
  - Active (mode, duty): loaded from pending on wrap.
- Write rules:
  - Writes never alter active state mid-period.
  - cfg_addr ≥ CHANNELS: write ignored.
  - Multiple writes to one channel within a period: last wins.
  - Write on the same edge as wrap: forwarded, so the written value becomes active at that boundary.
- Breathe generator (shared):
  - Registers: level `bri` (PWM_BITS), direction `up`, period counter 0..BREATHE_STEP-1.
  - On wrap the period counter advances. When it wraps, bri steps ±1.
  - up and bri == MAX-1 → bri = MAX, up = 0. Down and bri == 1 → bri = 0, up = 1.
  - bri therefore never leaves 0..MAX, and its full cycle is 2·MAX·BREATHE_STEP periods.
- LED output, registered every clk from active state and the current pwm_cnt:
  - off → 0.
  - on → 1.
  - pwm → (pwm_cnt < duty).
  - breathe → (pwm_cnt < min(bri, duty)).
- Duty edge values:
  - duty 0 → never lit.
  - duty MAX in pwm mode → lit MAX/2^PWM_BITS of the period. Full brightness requires mode on.
- Reset values: every output and register is 0, with up = 1. This covers prescaler, pwm_cnt, pending/active mode (off) and duty, bri, period counter, leds, and period_start.
- rst mid-period takes priority over cfg_we and wrap on the same edge. The first full period starts cleanly after release.

## Timing

- period_start <= wrap. It is high exactly during the first clk cycle with pwm_cnt == 0, once every PRESCALE·2^PWM_BITS cycles.
- After rst deasserts, the first period_start is at cycle PRESCALE·2^PWM_BITS, counting the first non-reset cycle as cycle 0 (the boundary edge lands at cycle PRESCALE·2^PWM_BITS − 1).
- leds lag pwm_cnt by one cycle. In the period_start cycle, leds still reflect the last step of the previous period.
- Config written at any cycle of period N is visible on leds from the cycle after period N+1's period_start.
- A bri step taken at a wrap applies to the period that wrap begins.
- No combinational path from cfg_* to any output.

## Test plan

All scenarios use CHANNELS=6, PWM_BITS=4, PRESCALE=2, BREATHE_STEP=1, giving a 32-cycle period.

- Reset: assert rst for 3 cycles mid-period with channel 0 lit.
  - leds=0 and period_start=0 on the edge after rst.
  - First period_start in the 33rd cycle after release (cycle 32 counting the first non-reset cycle as 0).
- PWM: write ch0 mode=2, duty=4.
  - After the next boundary, leds[0] is high for 8 consecutive clocks per 32, starting 1 cycle after period_start.
  - Other leds stay 0.
- Boundary behaviour:
  - ch1 mode=1 written mid-period: leds[1] stays 0 until 1 cycle after the next period_start.
  - ch1 mode=0 written on the wrap edge: applies at that boundary.
  - ch2 duty written 3 then 9 in one period: 18 high clocks.
- Breathe: ch3 mode=3, duty=15 from reset.
  - High clocks per period follow 2·bri: 0, 2, …, 30, then 28, 26, …, 0, then rising again.
  - Reversal at bri = 15 and bri = 0.
  - ch4 breathe with duty=5 caps at 10 high clocks.
- Duty extremes and address range:
  - duty=0 in pwm: never high.
  - duty=15 in pwm: low exactly 2 clocks per period.
  - Write to cfg_addr=7: all channels unchanged.
